serial_receiver: RTL

Deserialising stage directly downstream of the serial transmitter. Samples the serial bit line on each `transmission_clock` tick while the `transmission` framing line is high, assembling bits LSB first into a byte. Presents each completed byte with a valid/read handshake to the consuming logic. Optionally reports truncated frames, over-length frames and overrun.

---
 rtl/serial_pkg.sv | 18 +
 rtl/serial_shift_register.sv | 44 ++++
 rtl/serial_receiver.sv | 127 ++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared serial-link definitions: frame width, receiver state encoding and counter sizing.
package serial_pkg;

  localparam int unsigned SERIAL_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    DONE    = 2'd2,
    DRAIN   = 2'd3
  } rx_state_t;

  // Bit counter must hold the value DATA_WIDTH itself, hence the extra bit.
  function automatic int unsigned cnt_width(input int unsigned data_width);
    return $clog2(data_width) + 1;
  endfunction

endpackage

// File: rtl/serial_shift_register.sv
// Indexed capture register: writes one bit at the position given by its bit counter.
module serial_shift_register
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SERIAL_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = cnt_width(SERIAL_DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_capture,
  input  logic                  i_clear,
  input  logic                  i_bit,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_count
);

  localparam int unsigned IDX_WIDTH = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [IDX_WIDTH-1:0]  w_idx;
  logic                  w_room;

  assign w_idx  = r_count[IDX_WIDTH-1:0];
  assign w_room = (r_count < CNT_WIDTH'(DATA_WIDTH));

  // Counter saturates at DATA_WIDTH; captures beyond a full byte are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_capture && w_room) begin
      r_data[w_idx] <= i_bit;
      r_count       <= r_count + CNT_WIDTH'(1);
    end
  end

  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: rtl/serial_receiver.sv
// Serial byte receiver with valid/read handshake, LSB first.
// Optional SERIAL_RECEIVER_ERROR_EN adds frame_error for truncation, over-length and overrun.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SERIAL_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  transmission_clock,
  input  logic                  transmission,
  input  logic                  in_data,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
`ifdef SERIAL_RECEIVER_ERROR_EN
  ,
  output logic                  frame_error
`endif
);

  localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);

  rx_state_t             r_state;
  rx_state_t             w_state_nxt;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [CNT_W-1:0]      w_count;
  logic                  w_sample;
  logic                  w_last;
  logic                  w_capture;
  logic                  w_clear;
  logic                  w_load;

  assign w_sample = transmission_clock & transmission;
  assign w_last   = (w_count == CNT_W'(DATA_WIDTH - 1));

  serial_shift_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_W)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_capture (w_capture),
    .i_clear   (w_clear),
    .i_bit     (in_data),
    .o_data    (w_shift),
    .o_count   (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_sample) w_state_nxt = RECEIVE;
      RECEIVE: begin
        if (!transmission)                      w_state_nxt = IDLE;
        else if (transmission_clock && w_last)  w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = transmission ? DRAIN : IDLE;
      DRAIN:   if (!transmission) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_capture = 1'b0;
    w_clear   = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      IDLE:    w_capture = w_sample;
      RECEIVE: begin
        if (!transmission) w_clear   = 1'b1;
        else               w_capture = transmission_clock;
      end
      DONE: begin
        w_load  = 1'b1;
        w_clear = 1'b1;
      end
      default: ;
    endcase
  end

  // A load always leaves valid set, so a read in the DONE cycle loses to the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_shift;
      r_out_valid <= 1'b1;
    end else if (read) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

`ifdef SERIAL_RECEIVER_ERROR_EN
  logic r_frame_error;
  logic w_err;

  always_comb begin
    w_err = 1'b0;
    case (r_state)
      RECEIVE: w_err = ~transmission;
      DONE:    w_err = r_out_valid & ~read;
      DRAIN:   w_err = w_sample;
      default: w_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_error <= 1'b0;
    else        r_frame_error <= w_err;
  end

  assign frame_error = r_frame_error;
`endif

endmodule
